// File: rtl/hps_uio_pkg.sv
// hps_uio_pkg: shared definitions for the HPS UIO command dispatcher.
//   - UIO command codes (16-bit, compared against the full first word)
//   - kms event type enum (2-bit tag stored with each FIFO entry)
//   - joy_index(): maps a joystick command to its channel (7 = not a joy cmd)
package hps_uio_pkg;

  localparam logic [15:0] CMD_CFG   = 16'h0001;
  localparam logic [15:0] CMD_JOY0  = 16'h0002;
  localparam logic [15:0] CMD_JOY1  = 16'h0003;
  localparam logic [15:0] CMD_MOUSE = 16'h0004;
  localparam logic [15:0] CMD_KBD   = 16'h0005;
  localparam logic [15:0] CMD_OSD   = 16'h0006;
  localparam logic [15:0] CMD_CONF  = 16'h0014;
  localparam logic [15:0] CMD_JOY2  = 16'h0016;
  localparam logic [15:0] CMD_JOY3  = 16'h0017;
  localparam logic [15:0] CMD_JOY4  = 16'h0018;
  localparam logic [15:0] CMD_JOY5  = 16'h0019;
  localparam logic [15:0] CMD_RTC   = 16'h0022;
  localparam logic [15:0] CMD_STAT  = 16'h002A;

  localparam int KMS_W = 10;  // {type[1:0], data[7:0]}

  typedef enum logic [1:0] {
    KMS_MOUSE_X = 2'd0,
    KMS_MOUSE_Y = 2'd1,
    KMS_KEY     = 2'd2,
    KMS_OSD     = 2'd3
  } kms_type_e;

  localparam logic [2:0] JOY_NONE = 3'd7;

  function automatic logic [2:0] joy_index(input logic [15:0] cmd);
    logic [2:0] idx;
    idx = JOY_NONE;
    case (cmd)
      CMD_JOY0: idx = 3'd0;
      CMD_JOY1: idx = 3'd1;
      CMD_JOY2: idx = 3'd2;
      CMD_JOY3: idx = 3'd3;
      CMD_JOY4: idx = 3'd4;
      CMD_JOY5: idx = 3'd5;
      default:  idx = JOY_NONE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/hps_uio_kms_fifo.sv
// hps_uio_kms_fifo: keyboard/mouse/OSD event queue.
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i, din_i  enqueue request and 10-bit entry
//   pop_i          dequeue request, ignored while empty
//   dout_o         head entry (registered storage, valid when !empty_o)
//   level_o        occupancy 0..DEPTH
//   full_o/empty_o status
//   drop_o         push refused this cycle (full and no pop)
// A pop frees the slot in the same cycle, so push+pop while full is accepted.
module hps_uio_kms_fifo
  import hps_uio_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [KMS_W-1:0] din_i,
  input  logic             pop_i,
  output logic [KMS_W-1:0] dout_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  logic [KMS_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;
  assign dout_o  = mem_q[rd_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/hps_uio_dispatch.sv
// hps_uio_dispatch: UIO command decoder between the HPS bus and the Minimig core.
//   clk_sys, reset        clock, synchronous active-high reset
//   uio_ena               transaction frame (low ends it, clears word count)
//   io_strobe, io_din     one pulse per 16-bit word from the HPS
//   io_dout               registered reply, sampled by the HPS one word later
//   conf_str              config string, first character in the MSBs
//   joy                   JOY_COUNT x 16-bit joystick words
//   cfg, mouse_buttons    latched config byte / mouse buttons
//   kms_*                 event FIFO head with valid/ready pop, sticky overflow
//   rtc, rtc_stb          RTC words and completion pulse
// Optional feature: define HPS_UIO_RTC_EN to enable command 0x22 (RTC);
// otherwise rtc/rtc_stb are tied to 0 and 0x22 decodes as unknown.
module hps_uio_dispatch
  import hps_uio_pkg::*;
#(
  parameter int JOY_COUNT = 4,
  parameter int STRLEN    = 0,
  parameter int KMS_DEPTH = 8,
  localparam int CSW      = (STRLEN > 0) ? 8 * STRLEN : 8
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    uio_ena,
  input  logic                    io_strobe,
  input  logic [15:0]             io_din,
  output logic [15:0]             io_dout,
  input  logic [CSW-1:0]          conf_str,
  output logic [16*JOY_COUNT-1:0] joy,
  output logic [7:0]              cfg,
  output logic                    kms_valid,
  input  logic                    kms_ready,
  output logic [1:0]              kms_type,
  output logic [7:0]              kms_data,
  output logic                    kms_overflow,
  output logic [2:0]              mouse_buttons,
  output logic [63:0]             rtc,
  output logic                    rtc_stb
);

  localparam int LW = $clog2(KMS_DEPTH) + 1;

  logic                           armed_q, armed_d;
  logic [9:0]                     wcnt_q, wcnt_d;
  logic [15:0]                    cmd_q, cmd_d;
  logic [15:0]                    io_dout_q, io_dout_d;
  logic [JOY_COUNT-1:0][15:0]     joy_q, joy_d;
  logic [7:0]                     cfg_q, cfg_d;
  logic [2:0]                     mbtn_q, mbtn_d;
  logic                           ovf_q, ovf_d;

  logic                           accept;
  logic                           push;
  logic [KMS_W-1:0]               push_data;
  logic                           stat_clr;
  logic [2:0]                     jidx;

  logic [KMS_W-1:0]               fifo_dout;
  logic [LW-1:0]                  fifo_level;
  logic                           fifo_full, fifo_empty, fifo_drop;
  logic [6:0]                     level7;

  // With STRLEN=0 the string port is a one-byte stub and carries nothing.
  logic unused_conf;
  assign unused_conf = ^conf_str;

`ifdef HPS_UIO_RTC_EN
  logic [63:0] rtc_q, rtc_d;
  logic        rtc_stb_q, rtc_stb_d;
  logic        ena_q;
`endif

  // Strobes before the first observed idle (uio_ena low) may land mid-frame.
  assign accept = armed_q & uio_ena & io_strobe;
  assign level7 = 7'(fifo_level);
  assign jidx   = joy_index(cmd_q);

  always_comb begin
    armed_d   = armed_q | ~uio_ena;
    wcnt_d    = wcnt_q;
    cmd_d     = cmd_q;
    io_dout_d = io_dout_q;
    joy_d     = joy_q;
    cfg_d     = cfg_q;
    mbtn_d    = mbtn_q;
    push      = 1'b0;
    push_data = '0;
    stat_clr  = 1'b0;
`ifdef HPS_UIO_RTC_EN
    rtc_d     = rtc_q;
    rtc_stb_d = ena_q & ~uio_ena & armed_q & (cmd_q == CMD_RTC) & (wcnt_q >= 10'd5);
`endif

    if (!uio_ena) begin
      wcnt_d = '0;
    end else if (accept) begin
      if (wcnt_q != 10'd1023) wcnt_d = wcnt_q + 10'd1;
      io_dout_d = '0;
      if (wcnt_q == '0) begin
        cmd_d = io_din;
        if (io_din == CMD_STAT) begin
          io_dout_d = {ovf_q, 8'd0, level7};
          stat_clr  = 1'b1;
        end
      end else begin
        case (cmd_q)
          CMD_CFG: cfg_d = io_din[7:0];
          CMD_MOUSE: begin
            if (wcnt_q == 10'd1) begin
              push = 1'b1; push_data = {KMS_MOUSE_X, io_din[7:0]};
            end else if (wcnt_q == 10'd2) begin
              push = 1'b1; push_data = {KMS_MOUSE_Y, io_din[7:0]};
            end else if (wcnt_q == 10'd3) begin
              mbtn_d = io_din[2:0];
            end
          end
          CMD_KBD: if (wcnt_q == 10'd1) begin
            push = 1'b1; push_data = {KMS_KEY, io_din[7:0]};
          end
          CMD_OSD: if (wcnt_q == 10'd1) begin
            push = 1'b1; push_data = {KMS_OSD, io_din[7:0]};
          end
          CMD_CONF: begin
            // Word n returns byte n-1 counted from the MSB end; beyond STRLEN stays 0.
            for (int i = 0; i < STRLEN; i++)
              if (wcnt_q == 10'(i + 1)) io_dout_d[7:0] = conf_str[8*(STRLEN-1-i) +: 8];
          end
`ifdef HPS_UIO_RTC_EN
          CMD_RTC: begin
            for (int i = 0; i < 4; i++)
              if (wcnt_q == 10'(i + 1)) rtc_d[16*i +: 16] = io_din;
          end
`endif
          default: ;
        endcase
        if (wcnt_q == 10'd1)
          for (int j = 0; j < JOY_COUNT; j++)
            if (jidx == 3'(j)) joy_d[j] = io_din;
      end
    end

    // A drop in the same cycle as a status read keeps the flag set.
    ovf_d = ovf_q;
    if (stat_clr)  ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      armed_q   <= 1'b0;
      wcnt_q    <= '0;
      cmd_q     <= '0;
      io_dout_q <= '0;
      joy_q     <= '0;
      cfg_q     <= '0;
      mbtn_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      wcnt_q    <= wcnt_d;
      cmd_q     <= cmd_d;
      io_dout_q <= io_dout_d;
      joy_q     <= joy_d;
      cfg_q     <= cfg_d;
      mbtn_q    <= mbtn_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef HPS_UIO_RTC_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rtc_q     <= '0;
      rtc_stb_q <= 1'b0;
      ena_q     <= 1'b0;
    end else begin
      rtc_q     <= rtc_d;
      rtc_stb_q <= rtc_stb_d;
      ena_q     <= uio_ena;
    end
  end
  assign rtc     = rtc_q;
  assign rtc_stb = rtc_stb_q;
`else
  assign rtc     = '0;
  assign rtc_stb = 1'b0;
`endif

  hps_uio_kms_fifo #(.DEPTH(KMS_DEPTH)) u_kms_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (kms_ready),
    .dout_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  logic unused_full;
  assign unused_full = fifo_full;

  assign io_dout       = io_dout_q;
  assign joy           = joy_q;
  assign cfg           = cfg_q;
  assign mouse_buttons = mbtn_q;
  assign kms_overflow  = ovf_q;
  assign kms_valid     = ~fifo_empty;
  assign kms_type      = fifo_dout[9:8];
  assign kms_data      = fifo_dout[7:0];

endmodule

// File: tb/tb_hps_uio_dispatch.sv
// tb_hps_uio_dispatch: directed self-checking bench for hps_uio_dispatch
// (JOY_COUNT=4, STRLEN=3 "A;B", KMS_DEPTH=8). Inputs change on the falling
// edge and outputs are sampled on the falling edge after each rising edge.
module tb_hps_uio_dispatch;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        uio_ena;
  logic        io_strobe;
  logic [15:0] io_din;
  logic [15:0] io_dout;
  logic [23:0] conf_str;
  logic [63:0] joy;
  logic [7:0]  cfg;
  logic        kms_valid;
  logic        kms_ready;
  logic [1:0]  kms_type;
  logic [7:0]  kms_data;
  logic        kms_overflow;
  logic [2:0]  mouse_buttons;
  logic [63:0] rtc;
  logic        rtc_stb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  hps_uio_dispatch #(.JOY_COUNT(4), .STRLEN(3), .KMS_DEPTH(8)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .uio_ena       (uio_ena),
    .io_strobe     (io_strobe),
    .io_din        (io_din),
    .io_dout       (io_dout),
    .conf_str      (conf_str),
    .joy           (joy),
    .cfg           (cfg),
    .kms_valid     (kms_valid),
    .kms_ready     (kms_ready),
    .kms_type      (kms_type),
    .kms_data      (kms_data),
    .kms_overflow  (kms_overflow),
    .mouse_buttons (mouse_buttons),
    .rtc           (rtc),
    .rtc_stb       (rtc_stb)
  );

  // All stimulus tasks start and end just after a falling edge.
  task automatic strobe(input logic [15:0] w);
    io_din    = w;
    io_strobe = 1'b1;
    @(negedge clk_sys);
    io_strobe = 1'b0;
  endtask

  task automatic frame_begin();
    uio_ena = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic frame_end();
    uio_ena = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset = 1'b1; uio_ena = 1'b1;
    repeat (3) @(negedge clk_sys);
    n_checks++; if (io_dout !== 16'h0) begin n_fail++; $display("FAIL reset_io_dout got=%h exp=0000", io_dout); end
    n_checks++; if (joy !== 64'h0) begin n_fail++; $display("FAIL reset_joy got=%h exp=0", joy); end
    n_checks++; if (kms_valid !== 1'b0 || kms_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_kms got=%b%b exp=00", kms_valid, kms_overflow); end
    n_checks++; if (cfg !== 8'h0 || mouse_buttons !== 3'h0 || rtc !== 64'h0 || rtc_stb !== 1'b0) begin
      n_fail++; $display("FAIL reset_misc cfg=%h mb=%h rtc=%h stb=%b exp all 0", cfg, mouse_buttons, rtc, rtc_stb); end
    // Release reset mid-frame: these words must not be decoded.
    reset = 1'b0;
    strobe(16'h0002); strobe(16'h1234); strobe(16'h0005);
    n_checks++; if (joy !== 64'h0 || cfg !== 8'h0) begin n_fail++; $display("FAIL unarmed_ignore joy=%h cfg=%h exp 0", joy, cfg); end
    n_checks++; if (kms_valid !== 1'b0) begin n_fail++; $display("FAIL unarmed_fifo got=%b exp=0", kms_valid); end
    frame_end();
    frame_begin(); strobe(16'h0002); strobe(16'h1234); frame_end();
    n_checks++; if (joy[15:0] !== 16'h1234) begin n_fail++; $display("FAIL armed_joy0 got=%h exp=1234", joy[15:0]); end
  endtask

  task automatic test_joy();
    frame_begin(); strobe(16'h0017); strobe(16'hBEEF); strobe(16'h5555); frame_end();
    n_checks++; if (joy[63:48] !== 16'hBEEF) begin n_fail++; $display("FAIL joy3 got=%h exp=beef", joy[63:48]); end
    // Index 4 and 5 are beyond JOY_COUNT=4.
    frame_begin(); strobe(16'h0018); strobe(16'hAAAA); frame_end();
    frame_begin(); strobe(16'h0019); strobe(16'hCCCC); frame_end();
    n_checks++; if (joy !== 64'hBEEF_0000_0000_1234) begin n_fail++; $display("FAIL joy_oob got=%h exp=beef000000001234", joy); end
  endtask

  task automatic test_cfg();
    frame_begin(); strobe(16'h0001); strobe(16'h00AB);
    n_checks++; if (cfg !== 8'hAB) begin n_fail++; $display("FAIL cfg_first got=%h exp=ab", cfg); end
    strobe(16'h12CD); frame_end();
    n_checks++; if (cfg !== 8'hCD) begin n_fail++; $display("FAIL cfg_last got=%h exp=cd", cfg); end
    frame_begin(); strobe(16'h0033); strobe(16'h00EE);
    n_checks++; if (io_dout !== 16'h0 || cfg !== 8'hCD) begin n_fail++; $display("FAIL unknown_cmd dout=%h cfg=%h exp 0000/cd", io_dout, cfg); end
    frame_end();
  endtask

  task automatic test_mouse();
    kms_ready = 1'b1;
    frame_begin();
    strobe(16'h0004);
    strobe(16'h0005);
    n_checks++; if (kms_valid !== 1'b1 || kms_type !== 2'd0 || kms_data !== 8'h05) begin
      n_fail++; $display("FAIL mouse_x v=%b t=%0d d=%h exp 1/0/05", kms_valid, kms_type, kms_data); end
    strobe(16'h00FB);
    n_checks++; if (kms_valid !== 1'b1 || kms_type !== 2'd1 || kms_data !== 8'hFB) begin
      n_fail++; $display("FAIL mouse_y v=%b t=%0d d=%h exp 1/1/fb", kms_valid, kms_type, kms_data); end
    strobe(16'h0003);
    n_checks++; if (mouse_buttons !== 3'd3 || kms_valid !== 1'b0) begin
      n_fail++; $display("FAIL mouse_btn mb=%0d v=%b exp 3/0", mouse_buttons, kms_valid); end
    frame_end();
    kms_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      frame_begin(); strobe(16'h0005); strobe(16'h0010 + 16'(i)); frame_end();
    end
    n_checks++; if (kms_valid !== 1'b1 || kms_type !== 2'd2 || kms_data !== 8'h10) begin
      n_fail++; $display("FAIL ovf_head v=%b t=%0d d=%h exp 1/2/10", kms_valid, kms_type, kms_data); end
    n_checks++; if (kms_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", kms_overflow); end
    frame_begin(); strobe(16'h002A);
    n_checks++; if (io_dout !== 16'h8008) begin n_fail++; $display("FAIL status1 got=%h exp=8008", io_dout); end
    n_checks++; if (kms_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", kms_overflow); end
    strobe(16'h0000);
    n_checks++; if (io_dout !== 16'h0) begin n_fail++; $display("FAIL status_operand got=%h exp=0000", io_dout); end
    frame_end();
    frame_begin(); strobe(16'h002A);
    n_checks++; if (io_dout !== 16'h0008) begin n_fail++; $display("FAIL status2 got=%h exp=0008", io_dout); end
    frame_end();
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q [8];
    frame_begin(); strobe(16'h0005);
    kms_ready = 1'b1;
    strobe(16'h0077);
    kms_ready = 1'b0;
    frame_end();
    n_checks++; if (kms_overflow !== 1'b0 || kms_data !== 8'h11) begin
      n_fail++; $display("FAIL full_pop ovf=%b head=%h exp 0/11", kms_overflow, kms_data); end
    frame_begin(); strobe(16'h002A);
    n_checks++; if (io_dout !== 16'h0008) begin n_fail++; $display("FAIL full_pop_level got=%h exp=0008", io_dout); end
    frame_end();
    for (int i = 0; i < 7; i++) exp_q[i] = 8'h11 + 8'(i);
    exp_q[7] = 8'h77;
    kms_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (kms_valid !== 1'b1 || kms_data !== exp_q[i]) begin
        n_fail++; $display("FAIL drain[%0d] v=%b d=%h exp 1/%h", i, kms_valid, kms_data, exp_q[i]); end
      @(negedge clk_sys);
    end
    repeat (2) @(negedge clk_sys);
    n_checks++; if (kms_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", kms_valid); end
    kms_ready = 1'b0;
  endtask

  task automatic test_conf();
    logic [15:0] exp_q [4];
    exp_q[0] = 16'h0041; exp_q[1] = 16'h003B; exp_q[2] = 16'h0042; exp_q[3] = 16'h0000;
    frame_begin(); strobe(16'h0014);
    n_checks++; if (io_dout !== 16'h0) begin n_fail++; $display("FAIL conf_cmd got=%h exp=0000", io_dout); end
    for (int i = 0; i < 4; i++) begin
      strobe(16'hFFFF);
      n_checks++; if (io_dout !== exp_q[i]) begin n_fail++; $display("FAIL conf[%0d] got=%h exp=%h", i, io_dout, exp_q[i]); end
    end
    frame_end();
  endtask

  task automatic test_rtc();
    int pulses;
    logic [63:0] exp_rtc;
    int exp_pulses;
`ifdef HPS_UIO_RTC_EN
    exp_rtc = 64'h4444_3333_2222_1111; exp_pulses = 1;
`else
    exp_rtc = 64'h0; exp_pulses = 0;
`endif
    frame_begin(); strobe(16'h0022);
    strobe(16'h1111); strobe(16'h2222); strobe(16'h3333); strobe(16'h4444);
    n_checks++; if (rtc !== exp_rtc) begin n_fail++; $display("FAIL rtc_value got=%h exp=%h", rtc, exp_rtc); end
    n_checks++; if (rtc_stb !== 1'b0) begin n_fail++; $display("FAIL rtc_stb_early got=%b exp=0", rtc_stb); end
    uio_ena = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      if (rtc_stb === 1'b1) pulses++;
    end
    n_checks++; if (pulses != exp_pulses) begin n_fail++; $display("FAIL rtc_stb_count got=%0d exp=%0d", pulses, exp_pulses); end
  endtask

  initial begin
    reset = 1'b1; uio_ena = 1'b0; io_strobe = 1'b0; io_din = 16'h0;
    kms_ready = 1'b0; conf_str = 24'h413B42;
    @(negedge clk_sys);
    test_reset();
    test_joy();
    test_cfg();
    test_mouse();
    test_overflow();
    test_full_pop();
    test_conf();
    test_rtc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
